// File: rtl/aes_block_loader_if.sv
// Byte-stream and block-presentation signals for aes_block_loader.
// slave modport: the loader. master modport: the byte source and encrypt core side.
`timescale 1ns/1ps
interface aes_block_loader_if;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_is_key;
  logic         s_ready;
  logic [127:0] m_state;
  logic [127:0] m_key;
  logic         m_valid;
  logic         m_ready;
  logic         key_loaded;
  logic         err;

  modport slave (
    input  s_data, s_valid, s_is_key, m_ready,
    output s_ready, m_state, m_key, m_valid, key_loaded, err
  );

  modport master (
    output s_data, s_valid, s_is_key, m_ready,
    input  s_ready, m_state, m_key, m_valid, key_loaded, err
  );
endinterface

// File: rtl/aes_block_loader.sv
// aes_block_loader: assembles byte-serial key and plaintext blocks for the
// AES-128 encrypt core. The key is held until a new key block completes;
// plaintext blocks are presented as {m_state, m_key} under valid/ready.
// Optional build macro LOADER_TIMEOUT_EN: aborts a partial block after
// TIMEOUT_CYC consecutive idle cycles mid-block.
`timescale 1ns/1ps
module aes_block_loader #(
  parameter int unsigned NBYTES = 16
`ifdef LOADER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  aes_block_loader_if.slave   bus
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned SW = W - 8;

  typedef enum logic [1:0] {IDLE, LOAD_KEY, LOAD_DATA, PRESENT} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt;
  logic [SW-1:0]  key_shadow;
  logic [SW-1:0]  data_shadow;
  logic [W-1:0]   m_state_q;
  logic [W-1:0]   m_key_q;
  logic           m_valid_q;
  logic           key_loaded_q;
  logic           err_q;
  logic           rdy_en;
  logic           s_ready;
  logic           xfer;
  logic           last_byte;
  logic           to_key;
  logic           timeout;
  logic           loading;

  assign loading   = (state == LOAD_KEY) || (state == LOAD_DATA);
  assign s_ready   = (state != PRESENT) && rdy_en;
  assign xfer      = bus.s_valid && s_ready;
  assign last_byte = (cnt == 4'(NBYTES - 1));
  // s_is_key only matters on the first byte; afterwards the state decides.
  assign to_key    = (state == IDLE) ? bus.s_is_key : (state == LOAD_KEY);

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;

  assign timeout = loading && !bus.s_valid && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  // Idle counter: counts stalled cycles mid-block, cleared by any byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (loading && !bus.s_valid && !timeout) begin
      idle_cnt <= idle_cnt + TW'(1);
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Holds s_ready low for the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (xfer) state_nxt = bus.s_is_key ? LOAD_KEY : LOAD_DATA;
      end
      LOAD_KEY: begin
        if (xfer && last_byte) state_nxt = IDLE;
        else if (timeout)      state_nxt = IDLE;
      end
      LOAD_DATA: begin
        if (xfer && last_byte) state_nxt = key_loaded_q ? PRESENT : IDLE;
        else if (timeout)      state_nxt = IDLE;
      end
      PRESENT: begin
        if (bus.m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte counter, shadow registers, presented block, key and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      key_shadow   <= '0;
      data_shadow  <= '0;
      m_state_q    <= '0;
      m_key_q      <= '0;
      m_valid_q    <= 1'b0;
      key_loaded_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      m_valid_q <= (state_nxt == PRESENT);
      if (xfer) begin
        cnt <= last_byte ? '0 : cnt + 4'd1;
        if (to_key) key_shadow  <= {key_shadow[SW-9:0], bus.s_data};
        else        data_shadow <= {data_shadow[SW-9:0], bus.s_data};
        if (last_byte && state == LOAD_KEY) begin
          m_key_q      <= {key_shadow, bus.s_data};
          key_loaded_q <= 1'b1;
        end
        if (last_byte && state == LOAD_DATA) begin
          if (key_loaded_q) m_state_q <= {data_shadow, bus.s_data};
          else              err_q     <= 1'b1;
        end
      end else if (timeout) begin
        cnt   <= '0;
        err_q <= 1'b1;
      end
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.m_state    = m_state_q;
  assign bus.m_key      = m_key_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.key_loaded = key_loaded_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: directed FIPS-197 blocks plus
// randomized key/data traffic against a block-level reference model.
`timescale 1ns/1ps
module tb_aes_block_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  aes_block_loader_if bus();

  always #5 clk = ~clk;

`ifdef LOADER_TIMEOUT_EN
  aes_block_loader #(.NBYTES(16), .TIMEOUT_CYC(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  aes_block_loader #(.NBYTES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // Reference model: the held key and whether one is loaded.
  logic [127:0] ref_key = '0;
  bit           ref_key_loaded = 1'b0;
  logic [7:0]   blk [16];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // First byte received lands in the most significant byte.
  function automatic logic [127:0] pack_blk();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = blk[i];
    return v;
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
  endfunction

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input logic k, input int gap);
    int  n;
    bit  done;
    bus.s_valid  = 1'b0;
    bus.s_data   = 8'($urandom);
    bus.s_is_key = 1'($urandom);
    bus.m_ready  = 1'($urandom);
    repeat (gap) @(negedge clk);
    bus.s_data   = b;
    bus.s_is_key = k;
    bus.s_valid  = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      done = bus.s_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!done) check("byte_accept_wait", 128'(done), 128'd1);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
  endtask

  task automatic send_block(input bit is_key, input int maxgap);
    for (int i = 0; i < 16; i++)
      send_byte(blk[i], (i == 0) ? is_key : 1'($urandom), $urandom_range(maxgap, 0));
  endtask

  // Checks the outcome of a completed block; hold = cycles m_ready stays low in PRESENT.
  task automatic finish_block(input bit is_key, input int hold);
    logic [127:0] exp;
    exp = pack_blk();
    if (is_key) begin
      ref_key = exp;
      ref_key_loaded = 1'b1;
      check("key_loaded", 128'(bus.key_loaded), 128'd1);
      check("m_key", bus.m_key, ref_key);
      check("key_no_mvalid", 128'(bus.m_valid), 128'd0);
      check("key_s_ready", 128'(bus.s_ready), 128'd1);
      check("key_err", 128'(bus.err), 128'd0);
    end else if (ref_key_loaded) begin
      check("m_valid_latency", 128'(bus.m_valid), 128'd1);
      check("m_state", bus.m_state, exp);
      check("m_key_with_data", bus.m_key, ref_key);
      check("present_s_ready", 128'(bus.s_ready), 128'd0);
      check("data_err", 128'(bus.err), 128'd0);
      repeat (hold - 1) begin
        @(negedge clk);
        check("hold_m_valid", 128'(bus.m_valid), 128'd1);
        check("hold_m_state", bus.m_state, exp);
        check("hold_s_ready", 128'(bus.s_ready), 128'd0);
      end
      @(negedge clk);
      check("pre_hs_m_valid", 128'(bus.m_valid), 128'd1);
      bus.m_ready = 1'b1;
      @(negedge clk);
      bus.m_ready = 1'b0;
      check("post_hs_m_valid", 128'(bus.m_valid), 128'd0);
      check("post_hs_s_ready", 128'(bus.s_ready), 128'd1);
    end else begin
      check("nokey_err", 128'(bus.err), 128'd1);
      check("nokey_m_valid", 128'(bus.m_valid), 128'd0);
      check("nokey_key_loaded", 128'(bus.key_loaded), 128'd0);
      @(negedge clk);
      check("nokey_err_pulse", 128'(bus.err), 128'd0);
      check("nokey_m_valid2", 128'(bus.m_valid), 128'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_state"}, bus.m_state, 128'd0);
    check({tag, "_m_key"}, bus.m_key, 128'd0);
    check({tag, "_m_valid"}, 128'(bus.m_valid), 128'd0);
    check({tag, "_key_loaded"}, 128'(bus.key_loaded), 128'd0);
    check({tag, "_err"}, 128'(bus.err), 128'd0);
    check({tag, "_s_ready"}, 128'(bus.s_ready), 128'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    ref_key = '0;
    ref_key_loaded = 1'b0;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_s_ready", 128'(bus.s_ready), 128'd0);
    @(negedge clk);
    check("ready_after_release", 128'(bus.s_ready), 128'd1);
  endtask

  initial begin
    bus.s_data   = '0;
    bus.s_valid  = 1'b0;
    bus.s_is_key = 1'b0;
    bus.m_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    #1;
    check("por_release_s_ready", 128'(bus.s_ready), 128'd0);
    @(negedge clk);
    check("por_ready", 128'(bus.s_ready), 128'd1);

    // Plaintext before any key: consumed, err pulses, nothing presented.
    for (int i = 0; i < 16; i++) blk[i] = 8'(i * 17);
    send_block(1'b0, 0);
    finish_block(1'b0, 1);

    // FIPS-197 key, back to back.
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    send_block(1'b1, 0);
    check("fips_key", bus.m_key, 128'h000102030405060708090a0b0c0d0e0f);
    finish_block(1'b1, 1);

    // FIPS-197 plaintext, m_ready low for 5 cycles, handshake on the 6th.
    for (int i = 0; i < 16; i++) blk[i] = 8'(i * 17);
    send_block(1'b0, 0);
    check("fips_state", bus.m_state, 128'h00112233445566778899aabbccddeeff);
    finish_block(1'b0, 5);

    // Randomized mix of key reloads and data blocks with input stalls.
    for (int b = 0; b < 24; b++) begin
      bit k;
      k = ($urandom_range(3, 0) == 0);
      fill_random();
      send_block(k, 2);
      finish_block(k, $urandom_range(4, 1));
    end

    // Reset after byte 7 of a data block, then a clean key and data load.
    fill_random();
    for (int i = 0; i < 7; i++) send_byte(blk[i], (i == 0) ? 1'b0 : 1'($urandom), 0);
    do_reset();
    fill_random();
    send_block(1'b1, 1);
    finish_block(1'b1, 1);
    fill_random();
    send_block(1'b0, 1);
    finish_block(1'b0, 2);

`ifdef LOADER_TIMEOUT_EN
    // Five bytes then four idle cycles abort the block; key is kept.
    fill_random();
    for (int i = 0; i < 5; i++) send_byte(blk[i], 1'b0, 0);
    repeat (3) begin
      @(negedge clk);
      check("to_no_early_err", 128'(bus.err), 128'd0);
    end
    @(negedge clk);
    check("to_err", 128'(bus.err), 128'd1);
    check("to_key_kept", bus.m_key, ref_key);
    check("to_key_loaded", 128'(bus.key_loaded), 128'(ref_key_loaded));
    check("to_m_valid", 128'(bus.m_valid), 128'd0);
    @(negedge clk);
    check("to_err_pulse", 128'(bus.err), 128'd0);
    fill_random();
    send_block(1'b0, 1);
    finish_block(1'b0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
